io_stream_fifo_bridge: RTL and testbench
========================================

// Module: io_stream_fifo_bridge
// PURPOSE
//  Parametrised IO-port peripheral on the processor IO bus (port ID, read/write strobes).
//  Buffers bytes between the core and an external byte-stream engine (UART or similar)
//  through a TX FIFO and an RX FIFO.
//  Status ports: RX-data-present, TX-full, FIFO levels, sticky error flags.
//  Replaces fixed single-byte port stubs with configurable depth and port map.
// PARAMETERS
//  DEPTH         16     entries per FIFO; power of 2, 2..128
//  PORT_DATA     8'h01  read = pop RX FIFO, write = push TX FIFO
//  PORT_RX_AVAIL 8'h02  read: 8'hFF if RX FIFO non-empty, else 8'h00
//  PORT_TX_FULL  8'h03  read: 8'hFF if TX FIFO full, else 8'h00
//  PORT_RX_LVL   8'h04  read: RX occupancy, zero-extended to 8 bits
//  PORT_TX_LVL   8'h05  read: TX occupancy, zero-extended to 8 bits
//  PORT_ERR      8'h06  read: {6'b0, rx_underflow, tx_overflow}; write: bits set to 1 clear the flag
// PORTS
//  clk100           in   1  system clock; all state updates on rising edge
//  reset            in   1  synchronous reset, active-low (0 = reset)
//  IO_port_ID       in   8  port address from core
//  IO_write_data    in   8  write data from core
//  IO_write_strobe  in   1  1-cycle write qualifier
//  IO_read_strobe   in   1  1-cycle read qualifier
//  IO_read_data     out  8  read data to core (combinational)
//  tx_data          out  8  head of TX FIFO
//  tx_valid         out  1  TX FIFO non-empty
//  tx_ready         in   1  sink accepts tx_data when tx_valid & tx_ready
//  rx_data          in   8  byte from source
//  rx_valid         in   1  source presents rx_data
//  rx_ready         out  1  RX FIFO not full
// BEHAVIOUR
//  - Reset (reset==0 at a clock edge):
//    - Both FIFOs empty; pointers, counts and error flags cleared.
//    - Outputs: tx_valid=0, rx_ready=1, IO_read_data=0.
//    - Reset wins over any simultaneous strobe or stream transfer.
//  - Access semantics:
//    - Each cycle with a strobe high is one access.
//    - Both strobes high in the same cycle: read and write each act independently on IO_port_ID.
//    - Unmapped port IDs: reads return 8'h00, writes are ignored.
//  - IO_read_data: when IO_read_strobe=1, the mapped value from current registered state;
//    otherwise 8'h00.
//  - RX FIFO data read (IO_read_strobe & PORT_DATA):
//    - Returns the RX head byte combinationally in that cycle.
//    - Pops the entry at the clock edge.
//    - If empty: returns 8'h00, no pop, sets rx_underflow.
//  - TX FIFO data write (IO_write_strobe & PORT_DATA):
//    - Pushes IO_write_data at the edge.
//    - If full: byte dropped, sets tx_overflow.
//  - Stream side:
//    - TX pops when tx_valid & tx_ready.
//    - RX pushes when rx_valid & rx_ready.
//    - rx_ready=0 when RX full, so stream bytes are never lost.
//  - Same-edge push + pop on one FIFO: both take effect and count is unchanged.
//    - Full TX FIFO + write + tx pop in the same cycle: write accepted, no overflow.
//    - Empty RX FIFO + read + rx push in the same cycle: read returns 8'h00 and flags
//      underflow; the pushed byte stays.
//  - Latency: pushed byte visible at FIFO head one cycle after the push edge
//    (no fall-through within a cycle).
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//    Count is log2(DEPTH)+1 bits, range 0..DEPTH.
//  - Status values reflect state before the current edge.
//    Level ports report exact counts; DEPTH=128 reports 8'h80 when full.
//  - Error flags:
//    - Sticky until cleared by a write to PORT_ERR.
//    - A new error in the same cycle as a clear of that bit: set wins.
// TESTING
//  1 reset=0 two cycles with strobes active -> FIFOs empty, rx_ready=1, tx_valid=0,
//    read PORT_RX_AVAIL=8'h00, PORT_ERR=8'h00.
//  2 push rx 8'hA5,8'h3C via stream -> PORT_RX_LVL=2, PORT_RX_AVAIL=8'hFF;
//    two PORT_DATA reads return A5 then 3C; third read returns 00, PORT_ERR=8'h02.
//  3 tx_ready=0, write 17 bytes 0..16 to PORT_DATA (DEPTH=16) -> PORT_TX_FULL=8'hFF,
//    PORT_TX_LVL=16, PORT_ERR bit0=1; tx_ready=1 drains 0..15 in order, byte 16 absent.
//  4 TX full, write 8'h77 same cycle as tx handshake -> no overflow, count stays 16,
//    8'h77 emitted last.
//  5 rx_valid held with sink idle for 20 cycles -> rx_ready falls after 16 accepts,
//    exactly 16 stored; write 8'h03 to PORT_ERR clears all flags.
//  6 reset=0 mid-stream with 5 bytes in each FIFO -> next cycle both levels 0,
//    tx_valid=0, no spurious pop or push.

Source files
------------

// File: rtl/io_stream_fifo_bridge.sv
// IO-bus peripheral bridging the core to a byte-stream engine through TX and RX FIFOs.
// Exposes data, status, level and sticky error ports at configurable port IDs.
module io_stream_fifo_bridge #(
    parameter int unsigned DEPTH         = 16,
    parameter logic [7:0]  PORT_DATA     = 8'h01,
    parameter logic [7:0]  PORT_RX_AVAIL = 8'h02,
    parameter logic [7:0]  PORT_TX_FULL  = 8'h03,
    parameter logic [7:0]  PORT_RX_LVL   = 8'h04,
    parameter logic [7:0]  PORT_TX_LVL   = 8'h05,
    parameter logic [7:0]  PORT_ERR      = 8'h06
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic [7:0] IO_port_ID,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];

    logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CW-1:0] tx_cnt_q,    tx_cnt_d;
    logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0] rx_cnt_q,    rx_cnt_d;
    logic          tx_ovf_q,    tx_ovf_d;
    logic          rx_udf_q,    rx_udf_d;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic rd_data_acc, wr_data_acc, wr_err_acc;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_ovf_evt, rx_udf_evt;
    logic [7:0] rd_val;

    // FIFO status from registered counts
    always_comb begin
        tx_full  = (tx_cnt_q == CW'(DEPTH));
        tx_empty = (tx_cnt_q == '0);
        rx_full  = (rx_cnt_q == CW'(DEPTH));
        rx_empty = (rx_cnt_q == '0);
    end

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;
    assign tx_data  = tx_mem_q[tx_rd_ptr_q];

    // Access decode and transfer qualification
    always_comb begin
        rd_data_acc = IO_read_strobe  && (IO_port_ID == PORT_DATA);
        wr_data_acc = IO_write_strobe && (IO_port_ID == PORT_DATA);
        wr_err_acc  = IO_write_strobe && (IO_port_ID == PORT_ERR);

        tx_pop      = ~tx_empty & tx_ready;
        // A full TX FIFO still accepts a write when the stream pops the same edge
        tx_push     = wr_data_acc & (~tx_full | tx_pop);
        tx_ovf_evt  = wr_data_acc & tx_full & ~tx_pop;

        rx_push     = rx_valid & ~rx_full;
        // Underflow is judged on pre-edge occupancy; a same-cycle push does not rescue it
        rx_pop      = rd_data_acc & ~rx_empty;
        rx_udf_evt  = rd_data_acc & rx_empty;
    end

    // Next-state for pointers, counts and sticky flags
    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        tx_ovf_d    = tx_ovf_q;
        rx_udf_d    = rx_udf_q;

        if (tx_push) begin
            tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
        end
        if (tx_pop) begin
            tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
        end
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + CW'(1);
        end else if (tx_pop && !tx_push) begin
            tx_cnt_d = tx_cnt_q - CW'(1);
        end

        if (rx_push) begin
            rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
        end
        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
        end
        if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + CW'(1);
        end else if (rx_pop && !rx_push) begin
            rx_cnt_d = rx_cnt_q - CW'(1);
        end

        // Clear first, then set, so a same-cycle error wins over its clear
        if (wr_err_acc) begin
            tx_ovf_d = tx_ovf_d & ~IO_write_data[0];
            rx_udf_d = rx_udf_d & ~IO_write_data[1];
        end
        tx_ovf_d = tx_ovf_d | tx_ovf_evt;
        rx_udf_d = rx_udf_d | rx_udf_evt;
    end

    always_ff @(posedge clk100) begin
        if (!reset) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            tx_ovf_q    <= 1'b0;
            rx_udf_q    <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_udf_q    <= rx_udf_d;
        end
    end

    // Storage arrays carry no reset; occupancy is governed by the counts alone
    always_ff @(posedge clk100) begin
        if (reset && tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= IO_write_data;
        end
        if (reset && rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= rx_data;
        end
    end

    // Read-port mux over registered state
    always_comb begin
        rd_val = 8'h00;
        if (IO_port_ID == PORT_DATA) begin
            rd_val = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
        end else if (IO_port_ID == PORT_RX_AVAIL) begin
            rd_val = rx_empty ? 8'h00 : 8'hFF;
        end else if (IO_port_ID == PORT_TX_FULL) begin
            rd_val = tx_full ? 8'hFF : 8'h00;
        end else if (IO_port_ID == PORT_RX_LVL) begin
            rd_val = 8'(rx_cnt_q);
        end else if (IO_port_ID == PORT_TX_LVL) begin
            rd_val = 8'(tx_cnt_q);
        end else if (IO_port_ID == PORT_ERR) begin
            rd_val = {6'b0, rx_udf_q, tx_ovf_q};
        end
        IO_read_data = IO_read_strobe ? rd_val : 8'h00;
    end

endmodule

// File: tb/tb_io_stream_fifo_bridge.sv
// Directed bench for io_stream_fifo_bridge: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_io_stream_fifo_bridge;

    localparam int unsigned DEPTH = 16;

    logic       clk100 = 1'b0;
    logic       reset;
    logic [7:0] IO_port_ID;
    logic [7:0] IO_write_data;
    logic       IO_write_strobe;
    logic       IO_read_strobe;
    logic [7:0] IO_read_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    always #5 clk100 = ~clk100;

    io_stream_fifo_bridge #(.DEPTH(DEPTH)) dut (
        .clk100          (clk100),
        .reset           (reset),
        .IO_port_ID      (IO_port_ID),
        .IO_write_data   (IO_write_data),
        .IO_write_strobe (IO_write_strobe),
        .IO_read_strobe  (IO_read_strobe),
        .IO_read_data    (IO_read_data),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         m_ovf;
    bit         m_udf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd();
        if (!IO_read_strobe) return 8'h00;
        case (IO_port_ID)
            8'h01:   return (rxq.size() != 0) ? rxq[0] : 8'h00;
            8'h02:   return (rxq.size() != 0) ? 8'hFF : 8'h00;
            8'h03:   return (txq.size() == DEPTH) ? 8'hFF : 8'h00;
            8'h04:   return 8'(rxq.size());
            8'h05:   return 8'(txq.size());
            8'h06:   return {6'b0, m_udf, m_ovf};
            default: return 8'h00;
        endcase
    endfunction

    // Reference model: advances on each rising edge from the inputs held across it
    always @(posedge clk100) begin
        bit tpop, wr_d, rd_d, ovf_e, udf_e;
        if (!reset) begin
            txq.delete();
            rxq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            tpop  = tx_ready && (txq.size() != 0);
            wr_d  = IO_write_strobe && (IO_port_ID == 8'h01);
            rd_d  = IO_read_strobe && (IO_port_ID == 8'h01);
            ovf_e = 1'b0;
            udf_e = 1'b0;
            if (tpop) void'(txq.pop_front());
            if (wr_d) begin
                if (txq.size() < DEPTH) txq.push_back(IO_write_data);
                else ovf_e = 1'b1;
            end
            if (rd_d) begin
                if (rxq.size() != 0) void'(rxq.pop_front());
                else udf_e = 1'b1;
            end
            if (rx_valid && (rxq.size() < DEPTH || rd_d && rxq.size() == DEPTH && 1'b0))
                rxq.push_back(rx_data);
            if (IO_write_strobe && IO_port_ID == 8'h06) begin
                if (IO_write_data[0]) m_ovf = 1'b0;
                if (IO_write_data[1]) m_udf = 1'b0;
            end
            m_ovf = m_ovf | ovf_e;
            m_udf = m_udf | udf_e;
        end
        chk_en = 1'b1;
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk100) begin
        if (chk_en) begin
            check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
            check("rx_ready", 32'(rx_ready), 32'(rxq.size() != DEPTH));
            if (txq.size() != 0) check("tx_data", 32'(tx_data), 32'(txq[0]));
            check("io_read_data", 32'(IO_read_data), 32'(exp_rd()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk100);
            #1;
        end
    endtask

    task automatic rd(input logic [7:0] p, output logic [7:0] d);
        IO_read_strobe = 1'b1;
        IO_port_ID     = p;
        @(negedge clk100);
        d = IO_read_data;
        @(posedge clk100);
        #1;
        IO_read_strobe = 1'b0;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        IO_write_strobe = 1'b1;
        IO_port_ID      = p;
        IO_write_data   = d;
        @(posedge clk100);
        #1;
        IO_write_strobe = 1'b0;
    endtask

    task automatic drain(input int n, output logic [7:0] got[$]);
        got.delete();
        tx_ready = 1'b1;
        repeat (n) begin
            @(negedge clk100);
            if (tx_valid) got.push_back(tx_data);
            @(posedge clk100);
            #1;
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] got[$];
        int acc;

        // Reset held two cycles with strobes and stream activity present
        reset           = 1'b0;
        IO_read_strobe  = 1'b1;
        IO_write_strobe = 1'b1;
        IO_port_ID      = 8'h02;
        IO_write_data   = 8'h55;
        tx_ready        = 1'b0;
        rx_valid        = 1'b1;
        rx_data         = 8'h99;
        cyc(1);
        @(negedge clk100);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h1);
        check("rst_rx_avail", 32'(IO_read_data), 32'h00);
        #1 IO_port_ID = 8'h06;
        #1 check("rst_err", 32'(IO_read_data), 32'h00);
        @(posedge clk100);
        #1;
        reset           = 1'b1;
        IO_read_strobe  = 1'b0;
        IO_write_strobe = 1'b0;
        rx_valid        = 1'b0;
        rd(8'h04, d); check("rst_rx_lvl", 32'(d), 32'h00);
        rd(8'h05, d); check("rst_tx_lvl", 32'(d), 32'h00);

        // RX stream push then core reads, ending in underflow
        rx_valid = 1'b1;
        rx_data  = 8'hA5; cyc(1);
        rx_data  = 8'h3C; cyc(1);
        rx_valid = 1'b0;
        rd(8'h04, d); check("rx_lvl_2", 32'(d), 32'h02);
        rd(8'h02, d); check("rx_avail", 32'(d), 32'hFF);
        rd(8'h01, d); check("rx_pop_a5", 32'(d), 32'hA5);
        rd(8'h01, d); check("rx_pop_3c", 32'(d), 32'h3C);
        rd(8'h01, d); check("rx_pop_empty", 32'(d), 32'h00);
        rd(8'h06, d); check("err_udf", 32'(d), 32'h02);
        wr(8'h06, 8'h02);

        // TX overflow: 17 writes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) wr(8'h01, 8'(i));
        rd(8'h03, d); check("tx_full", 32'(d), 32'hFF);
        rd(8'h05, d); check("tx_lvl_16", 32'(d), 32'h10);
        rd(8'h06, d); check("err_ovf", 32'(d), 32'h01);
        drain(20, got);
        check("drain_cnt", 32'(got.size()), 32'd16);
        for (int i = 0; i < got.size(); i++) check("drain_byte", 32'(got[i]), 32'(i));
        wr(8'h06, 8'h01);

        // Full TX FIFO written on the same edge as a stream pop
        for (int i = 0; i < 16; i++) wr(8'h01, 8'(8'h40 + i));
        tx_ready = 1'b1;
        wr(8'h01, 8'h77);
        tx_ready = 1'b0;
        rd(8'h05, d); check("tx_lvl_kept", 32'(d), 32'h10);
        rd(8'h06, d); check("no_ovf", 32'(d), 32'h00);
        drain(20, got);
        check("drain2_cnt", 32'(got.size()), 32'd16);
        if (got.size() == 16) begin
            check("drain2_first", 32'(got[0]), 32'h41);
            check("drain2_last", 32'(got[15]), 32'h77);
        end

        // Both flags set, RX filled by a held stream, then cleared together
        rd(8'h01, d); check("udf_again", 32'(d), 32'h00);
        for (int i = 0; i < 17; i++) wr(8'h01, 8'(i));
        acc = 0;
        rx_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rx_data = 8'(8'h10 + k);
            @(negedge clk100);
            if (rx_ready) acc++;
            @(posedge clk100);
            #1;
        end
        rx_valid = 1'b0;
        check("rx_accepts", 32'(acc), 32'd16);
        check("rx_ready_low", 32'(rx_ready), 32'h0);
        rd(8'h04, d); check("rx_lvl_16", 32'(d), 32'h10);
        rd(8'h06, d); check("err_both", 32'(d), 32'h03);
        wr(8'h06, 8'h03);
        rd(8'h06, d); check("err_clr", 32'(d), 32'h00);
        rd(8'h01, d); check("rx_head_10", 32'(d), 32'h10);

        // Mid-stream reset with five bytes in each FIFO
        reset = 1'b0; cyc(1); reset = 1'b1;
        for (int i = 0; i < 5; i++) wr(8'h01, 8'(8'hB0 + i));
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_data = 8'(8'hC0 + i);
            cyc(1);
        end
        rx_valid = 1'b0;
        rd(8'h04, d); check("pre_rx_lvl", 32'(d), 32'h05);
        rd(8'h05, d); check("pre_tx_lvl", 32'(d), 32'h05);
        reset           = 1'b0;
        tx_ready        = 1'b1;
        rx_valid        = 1'b1;
        rx_data         = 8'hEE;
        IO_write_strobe = 1'b1;
        IO_port_ID      = 8'h01;
        IO_write_data   = 8'h99;
        cyc(1);
        reset           = 1'b1;
        tx_ready        = 1'b0;
        rx_valid        = 1'b0;
        IO_write_strobe = 1'b0;
        @(negedge clk100);
        check("post_tx_valid", 32'(tx_valid), 32'h0);
        check("post_rx_ready", 32'(rx_ready), 32'h1);
        @(posedge clk100);
        #1;
        rd(8'h04, d); check("post_rx_lvl", 32'(d), 32'h00);
        rd(8'h05, d); check("post_tx_lvl", 32'(d), 32'h00);

        // Empty-RX read on the same edge as a stream push
        IO_read_strobe = 1'b1;
        IO_port_ID     = 8'h01;
        rx_valid       = 1'b1;
        rx_data        = 8'h5A;
        @(negedge clk100);
        check("empty_rd_push", 32'(IO_read_data), 32'h00);
        @(posedge clk100);
        #1;
        IO_read_strobe = 1'b0;
        rx_valid       = 1'b0;
        rd(8'h06, d); check("udf_push", 32'(d), 32'h02);
        rd(8'h04, d); check("push_kept", 32'(d), 32'h01);
        rd(8'h01, d); check("push_byte", 32'(d), 32'h5A);
        rd(8'h07, d); check("unmapped", 32'(d), 32'h00);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
